// File: rtl/softmax_pass_sched_if.sv
// rtl/softmax_pass_sched_if.sv - control/issue bundle between the softmax pass scheduler and its datapath stages
// master = scheduler side, slave = datapath/controller side.
interface softmax_pass_sched_if #(
    parameter int IDX_W = 8
);
    logic             start;
    logic             stall;
    logic             abort;
    logic             rd_en;
    logic [IDX_W-1:0] rd_idx;
    logic [1:0]       pass;
    logic             first;
    logic             last;
    logic             busy;
    logic             done;

    modport master (
        input  start, stall, abort,
        output rd_en, rd_idx, pass, first, last, busy, done
    );

    modport slave (
        output start, stall, abort,
        input  rd_en, rd_idx, pass, first, last, busy, done
    );
endinterface

// File: rtl/softmax_pass_sched.sv
// rtl/softmax_pass_sched.sv - three-sweep (max, exp, norm) element scheduler with divider drain
// Optional cancel path enabled by defining SOFTMAX_SCHED_ABORT_EN.
module softmax_pass_sched #(
    parameter int VEC_LEN = 8,
    parameter int IDX_W   = 8,
    parameter int DIV_LAT = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    softmax_pass_sched_if.master  bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_MAX,
        S_EXP,
        S_NORM,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(VEC_LEN - 1);
    localparam logic [7:0]       DRAIN_LOAD = 8'(DIV_LAT);

    state_t           state;
    state_t           state_nxt;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] idx_nxt;
    logic [7:0]       drain_cnt;
    logic [7:0]       drain_nxt;
    logic [7:0]       drain_dec;
    logic             in_pass;
    logic             issue;
    logic             at_last;
    logic             abort_req;

`ifdef SOFTMAX_SCHED_ABORT_EN
    assign abort_req = bus.abort;
`else
    logic unused_abort;
    assign unused_abort = bus.abort;
    assign abort_req    = 1'b0;
`endif

    assign in_pass   = (state == S_MAX) || (state == S_EXP) || (state == S_NORM);
    assign issue     = in_pass && !bus.stall;
    assign at_last   = (idx == LAST_IDX);
    assign drain_dec = drain_cnt - 8'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            idx       <= '0;
            drain_cnt <= 8'd0;
        end else begin
            state     <= state_nxt;
            idx       <= idx_nxt;
            drain_cnt <= drain_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        drain_nxt = drain_cnt;
        case (state)
            S_IDLE: begin
                if (bus.start && !abort_req) begin
                    state_nxt = S_MAX;
                end
            end
            S_MAX, S_EXP, S_NORM: begin
                if (issue) begin
                    if (at_last) begin
                        // the wrap cycle both issues the last element and advances the sweep
                        idx_nxt = '0;
                        if (state == S_MAX) begin
                            state_nxt = S_EXP;
                        end else if (state == S_EXP) begin
                            state_nxt = S_NORM;
                        end else if (DIV_LAT == 0) begin
                            state_nxt = S_DONE;
                        end else begin
                            state_nxt = S_DRAIN;
                            drain_nxt = DRAIN_LOAD;
                        end
                    end else begin
                        idx_nxt = idx + IDX_W'(1);
                    end
                end
            end
            S_DRAIN: begin
                // counter reaches zero on the same edge that enters DONE
                drain_nxt = drain_dec;
                if (drain_dec == 8'd0) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        if (abort_req && (state != S_IDLE)) begin
            state_nxt = S_IDLE;
            idx_nxt   = '0;
            drain_nxt = 8'd0;
        end
    end

    assign bus.rd_en  = issue;
    assign bus.rd_idx = idx;
    assign bus.first  = issue && (idx == '0);
    assign bus.last   = issue && at_last;
    assign bus.busy   = (state != S_IDLE);
    assign bus.done   = (state == S_DONE);
    assign bus.pass   = (state == S_EXP)  ? 2'd1 :
                        (state == S_NORM) ? 2'd2 : 2'd0;

endmodule

// File: doc/softmax_pass_sched.md
# softmax_pass_sched

Pass scheduler for the softmax accelerator: on a start pulse it sequences the shared element datapath through three full sweeps of a vector (max-find, exp-and-accumulate, normalize), waits for the divider pipeline to drain, then pulses done. It drives the element read index, the pass select, and first/last flags consumed by the max register, exp accumulator and divider stages. It honours a datapath stall, and it owns the modulo element counter that these stages share.

## Interface
- VEC_LEN, 8: elements per vector; legal range is 1 to 2^IDX_W.
- IDX_W, 8: width of the element index.
- DIV_LAT, 4: divider pipeline depth, in cycles drained after the last NORM issue; legal range is 0 to 255.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request to begin a vector; sampled only in IDLE.
- stall  in  1  datapath back-pressure; freezes issue while high.
- abort  in  1  synchronous cancel; active only with SOFTMAX_SCHED_ABORT_EN, otherwise ignored.
- rd_en  out  1  element issue strobe for this cycle.
- rd_idx  out  IDX_W  element index being issued.
- pass  out  2  0 = MAX, 1 = EXP, 2 = NORM; meaningful only with rd_en.
- first  out  1  rd_en and rd_idx == 0; tells the stage to clear or load its accumulator.
- last  out  1  rd_en and rd_idx == VEC_LEN-1.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle completion pulse.

## Operation
- States are IDLE, MAX, EXP, NORM, DRAIN and DONE. Outputs derive combinationally from registered state, rd_idx and the drain counter.
- IDLE goes to MAX on start. rd_idx is already 0 on entry.
- In MAX, EXP and NORM:
  - rd_en = ~stall.
  - When rd_en is high, rd_idx increments. When rd_idx == VEC_LEN-1 it wraps to 0 instead.
  - The wrap cycle, with last high, advances the state: MAX to EXP, EXP to NORM, NORM to DRAIN.
- While stall is high: rd_en, first and last are 0, and rd_idx and state hold.
- On entering DRAIN, the drain counter loads DIV_LAT. It decrements every cycle and ignores stall. When it is 0 the state moves to DONE. With DIV_LAT = 0, NORM goes directly to DONE.
- DONE lasts one cycle with done = 1, then returns to IDLE.
- start outside IDLE, including in DONE, is ignored. Nothing queues it.
- For VEC_LEN = 1: every issue has first = last = 1, and each pass lasts one unstalled cycle.
- Arithmetic:
  - The rd_idx compare is against VEC_LEN-1, truncated to IDX_W bits.
  - The drain counter is 8 bits wide.
  - No output exceeds its declared width.
- Reset clears everything: state = IDLE; rd_idx, the drain counter and pass are 0; rd_en, first, last, busy and done are 0. Asserting reset mid-vector returns to IDLE immediately, and done is not produced.

## Timing
- If start is sampled at edge 0 and there is no stall:
  - MAX issues in cycles 1..N.
  - EXP issues in cycles N+1..2N.
  - NORM issues in cycles 2N+1..3N.
  - DRAIN occupies cycles 3N+1..3N+DIV_LAT.
  - done is high in cycle 3N+DIV_LAT+1.
  - (N = VEC_LEN.)
- Every stalled cycle during a pass adds exactly one cycle to the total. Stall has no effect in DRAIN, DONE or IDLE.
- The earliest next start is sampled in the cycle after done, i.e. the IDLE cycle.
- busy rises in the cycle after start is sampled. It falls in the cycle after done.

## Configuration
- SOFTMAX_SCHED_ABORT_EN defined:
  - abort = 1 in any busy state forces IDLE at the next edge.
  - rd_idx and the drain counter clear, and done is not pulsed.
  - abort takes priority over the pass advance and over DONE.
  - In IDLE, abort takes priority over start.
- SOFTMAX_SCHED_ABORT_EN undefined: the abort port exists but is unused, and behaviour is identical to abort = 0.

## Test plan
- VEC_LEN=4, DIV_LAT=2, no stall, start at cycle 0:
  - rd_idx runs 0,1,2,3 three times with pass 0, 1, 2.
  - first is high at cycles 1, 5, 9; last is high at cycles 4, 8, 12.
  - done is high only at cycle 15.
- Same configuration with stall high in cycles 3 and 7: issue holds, rd_idx does not change, and done moves to cycle 17.
- start held high through busy and DONE: only one vector runs. A second vector begins one cycle after the IDLE cycle that follows done.
- VEC_LEN=1, DIV_LAT=0: first = last = 1 in cycles 1, 2, 3, and done is high in cycle 4.
- rst_n pulsed low during the EXP pass: all outputs are 0 asynchronously, no done follows, and a fresh start runs normally.
- With SOFTMAX_SCHED_ABORT_EN, abort in cycle 6: busy = 0 and rd_idx = 0 in cycle 7, and done never pulses. Without the macro, the same stimulus completes normally.
